// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ioctl-to-SDRAM ROM loader.
package rom_loader_pkg;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned BANK_W = 2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned PAGE_W = 9;

  localparam logic [PAGE_W-1:0] PAGE_SYS0 = 9'h000;
  localparam logic [PAGE_W-1:0] PAGE_SYS1 = 9'h100;
  localparam logic [PAGE_W-1:0] PAGE_SYS2 = 9'h107;
  localparam logic [PAGE_W-1:0] PAGE_SYS3 = 9'h1FF;
  localparam logic [PAGE_W-1:0] PAGE_BAD  = 9'h1EE;

  localparam logic [7:0] CHAR_Z    = 8'h5A;
  localparam logic [7:0] CHAR_ZERO = 8'h30;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BANK_W-1:0] bank;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN
  } state_t;

  // Returns {valid, nibble} for an upper-case hex character.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, 4'(c - 8'h30)};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      r = {1'b1, 4'(c - 8'h37)};
    end
    return r;
  endfunction

endpackage

// File: rtl/rom_loader_fifo.sv
// Synchronous FIFO of loader entries; push and pop may coincide, even when full.
module rom_loader_fifo
  import rom_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        pop,
  output fifo_entry_t head_c,
  output logic        empty_c,
  output logic        full_c,
  output logic        push_ok_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  fifo_entry_t        store [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               pop_ok;

  assign empty_c   = (count == '0);
  assign full_c    = (count == CNT_W'(DEPTH));
  assign pop_ok    = pop && !empty_c;
  assign push_ok_c = push && (!full_c || pop_ok);
  assign head_c    = store[rd_ptr];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) store[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_c) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= PTR_W'(wr_ptr + PTR_W'(1));
      end
      if (pop_ok) rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
      case ({push_ok_c, pop_ok})
        2'b10:   count <= CNT_W'(count + CNT_W'(1));
        2'b01:   count <= CNT_W'(count - CNT_W'(1));
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_loader.sv
// ioctl download to SDRAM boot-write loader with expansion ROM presence map.
// Optional build macro: ROM_LOADER_COMBO_EN enables the "Z0" combo page switch.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  input  logic [31:0]       ioctl_file_ext,
  input  logic              model,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BANK_W-1:0] mem_bank,
  output logic [DATA_W-1:0] mem_din,
  input  logic              mem_ack,
  input  logic [7:0]        map_addr,
  output logic              map_hit,
  output logic              busy,
  output logic              overflow
);

  state_t            state, state_next;
  logic              dl_q, wr_q, dl_rise, wr_rise;
  logic              decode_en, capture_en;
  logic [PAGE_W-1:0] page, page_dec;
  logic              cap_valid, cap_hit;
  fifo_entry_t       cap_entry, head;
  logic [PAGE_W-1:0] a_hi;
  logic [BANK_W-1:0] bank_sel;
  logic [10:0]       sys_grp;
  logic              fifo_empty, fifo_full, push_ok;
  logic [255:0]      rom_map;
  logic [4:0]        hex_hi, hex_lo;
  logic              unused_ext;
`ifdef ROM_LOADER_COMBO_EN
  logic              combo, combo_dec;
`endif

  assign unused_ext = ^ioctl_file_ext[31:16];
  assign dl_rise    = ioctl_download && !dl_q;
  assign wr_rise    = ioctl_wr && !wr_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      dl_q  <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      state <= state_next;
      dl_q  <= ioctl_download;
      wr_q  <= ioctl_wr;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (dl_rise) state_next = ST_LOAD;
      ST_LOAD:  if (!ioctl_download) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (dl_rise) state_next = ST_LOAD;
        else if (fifo_empty && !cap_valid) state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    decode_en  = 1'b0;
    capture_en = 1'b0;
    case (state)
      ST_IDLE:  decode_en  = dl_rise;
      ST_LOAD:  capture_en = wr_rise;
      ST_DRAIN: decode_en  = dl_rise;
      default:  ;
    endcase
  end

  // Extension decode: each valid hex character overrides its nibble of the default page.
  assign hex_hi = hex_decode(ioctl_file_ext[15:8]);
  assign hex_lo = hex_decode(ioctl_file_ext[7:0]);

  always_comb begin
    page_dec = PAGE_BAD;
`ifdef ROM_LOADER_COMBO_EN
    combo_dec = 1'b0;
`endif
    if (ioctl_file_ext[15:8] == CHAR_Z && ioctl_file_ext[7:0] == CHAR_Z) begin
      page_dec = '0;
    end else if (ioctl_file_ext[15:8] == CHAR_Z && ioctl_file_ext[7:0] == CHAR_ZERO) begin
      page_dec = '0;
`ifdef ROM_LOADER_COMBO_EN
      combo_dec = 1'b1;
`endif
    end else begin
      if (hex_hi[4]) page_dec[7:4] = hex_hi[3:0];
      if (hex_lo[4]) page_dec[3:0] = hex_lo[3:0];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      page <= PAGE_BAD;
`ifdef ROM_LOADER_COMBO_EN
      combo <= 1'b0;
`endif
    end else if (decode_en) begin
      page <= page_dec;
`ifdef ROM_LOADER_COMBO_EN
      combo <= combo_dec;
    end else if (combo && push_ok && cap_entry.addr[13:0] == 14'h3FFF) begin
      page  <= PAGE_SYS3;
      combo <= 1'b0;
`endif
    end
  end

  // Address mapping: fixed system layout for index 0, page-relative otherwise.
  always_comb begin
    sys_grp  = ioctl_addr[24:14];
    cap_hit  = 1'b1;
    a_hi     = '0;
    bank_sel = '0;
    if (ioctl_index == 8'd0) begin
      cap_hit  = (sys_grp < 11'd8);
      bank_sel = {1'b0, sys_grp[2]};
      case (sys_grp[1:0])
        2'd0:    a_hi = PAGE_SYS0;
        2'd1:    a_hi = PAGE_SYS1;
        2'd2:    a_hi = PAGE_SYS2;
        default: a_hi = PAGE_SYS3;
      endcase
    end else begin
      a_hi     = {page[8], 8'(page[7:0] + ioctl_addr[21:14])};
      bank_sel = {1'b0, model};
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cap_valid <= 1'b0;
      cap_entry <= '0;
    end else begin
      cap_valid <= capture_en && cap_hit;
      if (capture_en) begin
        cap_entry.addr <= {a_hi, ioctl_addr[13:0]};
        cap_entry.bank <= bank_sel;
        cap_entry.data <= ioctl_dout;
      end
    end
  end

  rom_loader_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .push     (cap_valid),
    .push_data(cap_entry),
    .pop      (mem_ack),
    .head_c   (head),
    .empty_c  (fifo_empty),
    .full_c   (fifo_full),
    .push_ok_c(push_ok)
  );

  assign mem_req  = !fifo_empty;
  assign mem_addr = head.addr;
  assign mem_bank = head.bank;
  assign mem_din  = head.data;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= 1'b0;
      overflow <= 1'b0;
      rom_map  <= '0;
      map_hit  <= 1'b0;
    end else begin
      busy <= (state_next != ST_IDLE);
      if (dl_rise) overflow <= 1'b0;
      else if (cap_valid && fifo_full && !push_ok) overflow <= 1'b1;
      if (push_ok && cap_entry.addr[22]) rom_map[cap_entry.addr[21:14]] <= 1'b1;
      map_hit <= rom_map[map_addr];
    end
  end

endmodule
